// File: rtl/id_ex_stage_register_if.sv
// Signal bundle between the decode stage and the ID/EX stage register,
// including the EX/MEM and MEM/WB forwarding taps and the EX-facing outputs.
interface id_ex_stage_register_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int OP_WIDTH   = 4
);
  logic                  i_stall;
  logic                  i_flush;
  logic                  i_valid;
  logic [OP_WIDTH-1:0]   i_alu_op;
  logic [DATA_WIDTH-1:0] i_rs_data;
  logic [DATA_WIDTH-1:0] i_rt_data;
  logic [DATA_WIDTH-1:0] i_imm_ext;
  logic [4:0]            i_shamt;
  logic [REG_AW-1:0]     i_rs_addr;
  logic [REG_AW-1:0]     i_rt_addr;
  logic [REG_AW-1:0]     i_rd_addr;
  logic                  i_alu_src;
  logic                  i_reg_dst;
  logic                  i_reg_write;
  logic                  i_mem_read;
  logic                  i_mem_write;
  logic                  i_mem_to_reg;
  logic                  i_exmem_reg_write;
  logic [REG_AW-1:0]     i_exmem_rd;
  logic [DATA_WIDTH-1:0] i_exmem_result;
  logic                  i_memwb_reg_write;
  logic [REG_AW-1:0]     i_memwb_rd;
  logic [DATA_WIDTH-1:0] i_memwb_result;
  logic                  o_valid;
  logic [OP_WIDTH-1:0]   o_alu_op;
  logic [DATA_WIDTH-1:0] o_alu_a;
  logic [DATA_WIDTH-1:0] o_alu_b;
  logic [5:0]            o_shamt;
  logic [DATA_WIDTH-1:0] o_store_data;
  logic [REG_AW-1:0]     o_write_reg;
  logic                  o_reg_write;
  logic                  o_mem_read;
  logic                  o_mem_write;
  logic                  o_mem_to_reg;

  modport master (
    output i_stall, i_flush, i_valid, i_alu_op, i_rs_data, i_rt_data, i_imm_ext,
           i_shamt, i_rs_addr, i_rt_addr, i_rd_addr, i_alu_src, i_reg_dst,
           i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
           i_exmem_reg_write, i_exmem_rd, i_exmem_result,
           i_memwb_reg_write, i_memwb_rd, i_memwb_result,
    input  o_valid, o_alu_op, o_alu_a, o_alu_b, o_shamt, o_store_data,
           o_write_reg, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_alu_op, i_rs_data, i_rt_data, i_imm_ext,
           i_shamt, i_rs_addr, i_rt_addr, i_rd_addr, i_alu_src, i_reg_dst,
           i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
           i_exmem_reg_write, i_exmem_rd, i_exmem_result,
           i_memwb_reg_write, i_memwb_rd, i_memwb_result,
    output o_valid, o_alu_op, o_alu_a, o_alu_b, o_shamt, o_store_data,
           o_write_reg, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg
  );
endinterface

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register for the MIPS core: captures decoded fields, supports
// stall/flush, and forwards EX/MEM and MEM/WB results into the ALU operands.
module id_ex_stage_register #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int OP_WIDTH   = 4
) (
  input logic                     clk,
  input logic                     reset,
  id_ex_stage_register_if.slave   stage
);

  logic                  valid_r;
  logic [OP_WIDTH-1:0]   alu_op_r;
  logic [DATA_WIDTH-1:0] rs_data_r;
  logic [DATA_WIDTH-1:0] rt_data_r;
  logic [DATA_WIDTH-1:0] imm_r;
  logic [4:0]            shamt_r;
  logic [REG_AW-1:0]     rs_addr_r;
  logic [REG_AW-1:0]     rt_addr_r;
  logic [REG_AW-1:0]     write_reg_r;
  logic                  alu_src_r;
  logic                  reg_write_r;
  logic                  mem_read_r;
  logic                  mem_write_r;
  logic                  mem_to_reg_r;

  logic                  ex_hit_rs_s;
  logic                  ex_hit_rt_s;
  logic                  wb_hit_rs_s;
  logic                  wb_hit_rt_s;
  logic [DATA_WIDTH-1:0] fwd_rs_s;
  logic [DATA_WIDTH-1:0] fwd_rt_s;
  logic [REG_AW-1:0]     dest_s;

  // Register 0 is hardwired, so a producer targeting it never matches.
  function automatic logic fwd_hit(
    input logic              we,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] src
  );
    return we && (rd != {REG_AW{1'b0}}) && (rd == src);
  endfunction

  // Forwarding hit detection and operand selection; EX/MEM is the younger result.
  always_comb begin
    ex_hit_rs_s = fwd_hit(stage.i_exmem_reg_write, stage.i_exmem_rd, rs_addr_r);
    ex_hit_rt_s = fwd_hit(stage.i_exmem_reg_write, stage.i_exmem_rd, rt_addr_r);
    wb_hit_rs_s = fwd_hit(stage.i_memwb_reg_write, stage.i_memwb_rd, rs_addr_r);
    wb_hit_rt_s = fwd_hit(stage.i_memwb_reg_write, stage.i_memwb_rd, rt_addr_r);
    if (ex_hit_rs_s) begin
      fwd_rs_s = stage.i_exmem_result;
    end else if (wb_hit_rs_s) begin
      fwd_rs_s = stage.i_memwb_result;
    end else begin
      fwd_rs_s = rs_data_r;
    end
    if (ex_hit_rt_s) begin
      fwd_rt_s = stage.i_exmem_result;
    end else if (wb_hit_rt_s) begin
      fwd_rt_s = stage.i_memwb_result;
    end else begin
      fwd_rt_s = rt_data_r;
    end
  end

  // Destination register is resolved in decode so EX only sees the final index.
  always_comb begin
    if (stage.i_reg_dst) begin
      dest_s = stage.i_rd_addr;
    end else begin
      dest_s = stage.i_rt_addr;
    end
  end

  // Stage registers: reset > flush > stall > load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r      <= 1'b0;
      alu_op_r     <= {OP_WIDTH{1'b0}};
      rs_data_r    <= {DATA_WIDTH{1'b0}};
      rt_data_r    <= {DATA_WIDTH{1'b0}};
      imm_r        <= {DATA_WIDTH{1'b0}};
      shamt_r      <= 5'd0;
      rs_addr_r    <= {REG_AW{1'b0}};
      rt_addr_r    <= {REG_AW{1'b0}};
      write_reg_r  <= {REG_AW{1'b0}};
      alu_src_r    <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
    end else if (stage.i_flush) begin
      valid_r      <= 1'b0;
      alu_op_r     <= {OP_WIDTH{1'b0}};
      rs_data_r    <= {DATA_WIDTH{1'b0}};
      rt_data_r    <= {DATA_WIDTH{1'b0}};
      imm_r        <= {DATA_WIDTH{1'b0}};
      shamt_r      <= 5'd0;
      rs_addr_r    <= {REG_AW{1'b0}};
      rt_addr_r    <= {REG_AW{1'b0}};
      write_reg_r  <= {REG_AW{1'b0}};
      alu_src_r    <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
    end else if (stage.i_stall) begin
      // A MEM/WB producer retires during the stall; keep its value for later.
      if (wb_hit_rs_s) begin
        rs_data_r <= stage.i_memwb_result;
      end else begin
        rs_data_r <= rs_data_r;
      end
      if (wb_hit_rt_s) begin
        rt_data_r <= stage.i_memwb_result;
      end else begin
        rt_data_r <= rt_data_r;
      end
    end else begin
      valid_r      <= stage.i_valid;
      alu_op_r     <= stage.i_alu_op;
      rs_data_r    <= stage.i_rs_data;
      rt_data_r    <= stage.i_rt_data;
      imm_r        <= stage.i_imm_ext;
      shamt_r      <= stage.i_shamt;
      rs_addr_r    <= stage.i_rs_addr;
      rt_addr_r    <= stage.i_rt_addr;
      write_reg_r  <= dest_s;
      alu_src_r    <= stage.i_alu_src;
      reg_write_r  <= stage.i_reg_write;
      mem_read_r   <= stage.i_mem_read;
      mem_write_r  <= stage.i_mem_write;
      mem_to_reg_r <= stage.i_mem_to_reg;
    end
  end

  // EX-facing outputs; operands follow forwarding, everything else is the register.
  always_comb begin
    stage.o_valid      = valid_r;
    stage.o_alu_op     = alu_op_r;
    stage.o_alu_a      = fwd_rs_s;
    stage.o_shamt      = {1'b0, shamt_r};
    stage.o_store_data = fwd_rt_s;
    stage.o_write_reg  = write_reg_r;
    stage.o_reg_write  = reg_write_r;
    stage.o_mem_read   = mem_read_r;
    stage.o_mem_write  = mem_write_r;
    stage.o_mem_to_reg = mem_to_reg_r;
    if (alu_src_r) begin
      stage.o_alu_b = imm_r;
    end else begin
      stage.o_alu_b = fwd_rt_s;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed, table-driven bench for id_ex_stage_register: load/forwarding vectors
// plus hand-written reset, stall-refresh and flush-over-stall sequences.
module tb_id_ex_stage_register;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  id_ex_stage_register_if bus ();

  id_ex_stage_register dut (
    .clk   (clk),
    .reset (reset),
    .stage (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [3:0]  alu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        alu_src;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        exm_we;
    logic [4:0]  exm_rd;
    logic [31:0] exm_res;
    logic        mwb_we;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_res;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_store;
    logic [4:0]  e_wr;
    logic [5:0]  e_shamt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_stall = 1'b0; bus.i_flush = 1'b0; bus.i_valid = 1'b0;
    bus.i_alu_op = 4'd0; bus.i_rs_data = 32'd0; bus.i_rt_data = 32'd0;
    bus.i_imm_ext = 32'd0; bus.i_shamt = 5'd0; bus.i_rs_addr = 5'd0;
    bus.i_rt_addr = 5'd0; bus.i_rd_addr = 5'd0; bus.i_alu_src = 1'b0;
    bus.i_reg_dst = 1'b0; bus.i_reg_write = 1'b0; bus.i_mem_read = 1'b0;
    bus.i_mem_write = 1'b0; bus.i_mem_to_reg = 1'b0;
    bus.i_exmem_reg_write = 1'b0; bus.i_exmem_rd = 5'd0; bus.i_exmem_result = 32'd0;
    bus.i_memwb_reg_write = 1'b0; bus.i_memwb_rd = 5'd0; bus.i_memwb_result = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},     {31'd0, bus.o_valid},      32'd0);
    check({tag, ".alu_op"},    {28'd0, bus.o_alu_op},     32'd0);
    check({tag, ".alu_a"},     bus.o_alu_a,               32'd0);
    check({tag, ".alu_b"},     bus.o_alu_b,               32'd0);
    check({tag, ".shamt"},     {26'd0, bus.o_shamt},      32'd0);
    check({tag, ".store"},     bus.o_store_data,          32'd0);
    check({tag, ".write_reg"}, {27'd0, bus.o_write_reg},  32'd0);
    check({tag, ".ctrl"}, {28'd0, bus.o_reg_write, bus.o_mem_read, bus.o_mem_write,
                           bus.o_mem_to_reg}, 32'd0);
  endtask

  task automatic drive_decode(input vec_t v);
    bus.i_valid = v.valid; bus.i_alu_op = v.alu_op; bus.i_rs_data = v.rs_data;
    bus.i_rt_data = v.rt_data; bus.i_imm_ext = v.imm; bus.i_shamt = v.shamt;
    bus.i_rs_addr = v.rs; bus.i_rt_addr = v.rt; bus.i_rd_addr = v.rd;
    bus.i_alu_src = v.alu_src; bus.i_reg_dst = v.reg_dst; bus.i_reg_write = v.reg_write;
    bus.i_mem_read = v.mem_read; bus.i_mem_write = v.mem_write;
    bus.i_mem_to_reg = v.mem_to_reg;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;

    vecs[0] = '{name:"plain_add", valid:1'b1, alu_op:4'd3, rs_data:32'd5, rt_data:32'd7,
                imm:32'h1234, shamt:5'd0, rs:5'd1, rt:5'd2, rd:5'd9, alu_src:1'b0,
                reg_dst:1'b1, reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, mem_to_reg:1'b0,
                exm_we:1'b0, exm_rd:5'd0, exm_res:32'd0, mwb_we:1'b0, mwb_rd:5'd0, mwb_res:32'd0,
                e_a:32'd5, e_b:32'd7, e_store:32'd7, e_wr:5'd9, e_shamt:6'd0};
    vecs[1] = '{name:"double_hit", valid:1'b1, alu_op:4'd4, rs_data:32'd1, rt_data:32'd2,
                imm:32'd0, shamt:5'd0, rs:5'd8, rt:5'd8, rd:5'd10, alu_src:1'b0,
                reg_dst:1'b1, reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, mem_to_reg:1'b0,
                exm_we:1'b1, exm_rd:5'd8, exm_res:32'h11, mwb_we:1'b1, mwb_rd:5'd8, mwb_res:32'h22,
                e_a:32'h11, e_b:32'h11, e_store:32'h11, e_wr:5'd10, e_shamt:6'd0};
    vecs[2] = '{name:"memwb_only", valid:1'b1, alu_op:4'd4, rs_data:32'd1, rt_data:32'd2,
                imm:32'd0, shamt:5'd0, rs:5'd8, rt:5'd8, rd:5'd10, alu_src:1'b0,
                reg_dst:1'b1, reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, mem_to_reg:1'b0,
                exm_we:1'b0, exm_rd:5'd8, exm_res:32'h11, mwb_we:1'b1, mwb_rd:5'd8, mwb_res:32'h22,
                e_a:32'h22, e_b:32'h22, e_store:32'h22, e_wr:5'd10, e_shamt:6'd0};
    vecs[3] = '{name:"r0_guard", valid:1'b1, alu_op:4'd0, rs_data:32'd0, rt_data:32'h33,
                imm:32'd0, shamt:5'd0, rs:5'd0, rt:5'd3, rd:5'd11, alu_src:1'b0,
                reg_dst:1'b1, reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, mem_to_reg:1'b0,
                exm_we:1'b1, exm_rd:5'd0, exm_res:32'hFF, mwb_we:1'b1, mwb_rd:5'd0, mwb_res:32'hEE,
                e_a:32'd0, e_b:32'h33, e_store:32'h33, e_wr:5'd11, e_shamt:6'd0};
    vecs[4] = '{name:"imm_sll", valid:1'b1, alu_op:4'd5, rs_data:32'hA5A5_0000, rt_data:32'h44,
                imm:32'hFFFF_FFF0, shamt:5'd31, rs:5'd7, rt:5'd4, rd:5'd12, alu_src:1'b1,
                reg_dst:1'b0, reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, mem_to_reg:1'b0,
                exm_we:1'b1, exm_rd:5'd5, exm_res:32'h55, mwb_we:1'b1, mwb_rd:5'd4, mwb_res:32'h99,
                e_a:32'hA5A5_0000, e_b:32'hFFFF_FFF0, e_store:32'h99, e_wr:5'd4, e_shamt:6'd31};
    vecs[5] = '{name:"sw", valid:1'b1, alu_op:4'd3, rs_data:32'h100, rt_data:32'hDEAD_BEEF,
                imm:32'd8, shamt:5'd0, rs:5'd29, rt:5'd6, rd:5'd0, alu_src:1'b1,
                reg_dst:1'b0, reg_write:1'b0, mem_read:1'b0, mem_write:1'b1, mem_to_reg:1'b0,
                exm_we:1'b1, exm_rd:5'd29, exm_res:32'h200, mwb_we:1'b0, mwb_rd:5'd6, mwb_res:32'h1,
                e_a:32'h200, e_b:32'd8, e_store:32'hDEAD_BEEF, e_wr:5'd6, e_shamt:6'd0};
    vecs[6] = '{name:"lw", valid:1'b1, alu_op:4'd3, rs_data:32'h300, rt_data:32'h5,
                imm:32'hFFFF_FFFC, shamt:5'd0, rs:5'd2, rt:5'd13, rd:5'd0, alu_src:1'b1,
                reg_dst:1'b0, reg_write:1'b1, mem_read:1'b1, mem_write:1'b0, mem_to_reg:1'b1,
                exm_we:1'b0, exm_rd:5'd0, exm_res:32'd0, mwb_we:1'b0, mwb_rd:5'd0, mwb_res:32'd0,
                e_a:32'h300, e_b:32'hFFFF_FFFC, e_store:32'h5, e_wr:5'd13, e_shamt:6'd0};
    vecs[7] = '{name:"srl_nop", valid:1'b0, alu_op:4'd6, rs_data:32'h8000_0000, rt_data:32'hF0,
                imm:32'd0, shamt:5'd4, rs:5'd14, rt:5'd15, rd:5'd16, alu_src:1'b0,
                reg_dst:1'b1, reg_write:1'b0, mem_read:1'b0, mem_write:1'b0, mem_to_reg:1'b0,
                exm_we:1'b1, exm_rd:5'd15, exm_res:32'h0F, mwb_we:1'b1, mwb_rd:5'd14, mwb_res:32'h77,
                e_a:32'h77, e_b:32'h0F, e_store:32'h0F, e_wr:5'd16, e_shamt:6'd4};

    clear_inputs();
    reset = 1'b1;
    #2;
    check_all_zero("reset_init");
    tick();
    reset = 1'b0;

    // Vector table: load on one edge, apply forwarding taps, then sample.
    for (int i = 0; i < 8; i++) begin
      drive_decode(vecs[i]);
      tick();
      bus.i_exmem_reg_write = vecs[i].exm_we;
      bus.i_exmem_rd        = vecs[i].exm_rd;
      bus.i_exmem_result    = vecs[i].exm_res;
      bus.i_memwb_reg_write = vecs[i].mwb_we;
      bus.i_memwb_rd        = vecs[i].mwb_rd;
      bus.i_memwb_result    = vecs[i].mwb_res;
      #1;
      check({vecs[i].name, ".alu_a"},  bus.o_alu_a,  vecs[i].e_a);
      check({vecs[i].name, ".alu_b"},  bus.o_alu_b,  vecs[i].e_b);
      check({vecs[i].name, ".store"},  bus.o_store_data, vecs[i].e_store);
      check({vecs[i].name, ".write_reg"}, {27'd0, bus.o_write_reg}, {27'd0, vecs[i].e_wr});
      check({vecs[i].name, ".alu_op"}, {28'd0, bus.o_alu_op}, {28'd0, vecs[i].alu_op});
      check({vecs[i].name, ".shamt"},  {26'd0, bus.o_shamt}, {26'd0, vecs[i].e_shamt});
      check({vecs[i].name, ".ctrl"},
            {27'd0, bus.o_valid, bus.o_reg_write, bus.o_mem_read, bus.o_mem_write, bus.o_mem_to_reg},
            {27'd0, vecs[i].valid, vecs[i].reg_write, vecs[i].mem_read, vecs[i].mem_write,
             vecs[i].mem_to_reg});
      clear_inputs();
    end

    // Async reset while an ADD is loaded: outputs clear before any clock edge.
    drive_decode(vecs[0]);
    tick();
    check("pre_reset.alu_op", {28'd0, bus.o_alu_op}, 32'd3);
    clear_inputs();
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    #1;
    reset = 1'b0;
    tick();

    // Stall refresh: MEM/WB hits rt in the first stalled cycle only.
    drive_decode(vecs[5]);
    tick();
    bus.i_stall = 1'b1;
    bus.i_rt_data = 32'h77;
    bus.i_rd_addr = 5'd20;
    bus.i_reg_dst = 1'b1;
    bus.i_memwb_reg_write = 1'b1;
    bus.i_memwb_rd = 5'd6;
    bus.i_memwb_result = 32'hAB;
    #1;
    check("stall_c1.store", bus.o_store_data, 32'hAB);
    tick();
    bus.i_memwb_reg_write = 1'b0;
    bus.i_memwb_result = 32'h0;
    #1;
    check("stall_c2.store", bus.o_store_data, 32'hAB);
    check("stall_c2.write_reg", {27'd0, bus.o_write_reg}, 32'd6);
    tick();
    check("stall_c3.store", bus.o_store_data, 32'hAB);
    check("stall_c3.alu_b", bus.o_alu_b, 32'd8);
    tick();
    bus.i_stall = 1'b0;
    #1;
    check("stall_rel.store", bus.o_store_data, 32'hAB);
    check("stall_rel.mem_write", {31'd0, bus.o_mem_write}, 32'd1);
    clear_inputs();
    tick();

    // Flush beats stall on a loaded SW.
    drive_decode(vecs[5]);
    tick();
    check("pre_flush.mem_write", {31'd0, bus.o_mem_write}, 32'd1);
    bus.i_flush = 1'b1;
    bus.i_stall = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b0;
    #1;
    check_all_zero("flush_stall");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
